// File: rtl/sin_sample_scaler.sv
// Gain stage behind the sine LUT: Q1.15 scaling with round-half-up and saturation,
// followed by a small output FIFO with drop/saturation statistics.
module sin_sample_scaler #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16,
    parameter int FRAC   = 15,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_stats,
    input  logic [GAIN_W-1:0]          gain,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_sample,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_sample,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           sat_cnt
);

    localparam int P_W   = DATA_W + GAIN_W + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic signed [P_W:0] RND   = {{(P_W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [P_W:0] S_MAX = {{(P_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [P_W:0] S_MIN = {{(P_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [P_W-1:0]  p_q, p_d;
    logic                   v1_q, v1_d;
    logic [DATA_W-1:0]      r_q, r_d;
    logic                   v2_q, v2_d;
    logic                   sat_evt;
    logic signed [P_W:0]    p_ext, p_rnd, r_full;

    logic [DATA_W-1:0]      fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   full, pop, push, drop;

    logic                   overflow_q, overflow_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]       sat_cnt_q, sat_cnt_d;

    // Gain is captured together with its sample, so a gain change never touches in-flight data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        p_d    = $signed(in_sample) * $signed({1'b0, gain});
        v1_d   = in_valid;

        p_ext  = {p_q[P_W-1], p_q};
        p_rnd  = p_ext + RND;
        r_full = p_rnd >>> FRAC;
        r_d    = r_full[DATA_W-1:0];
        sat_evt = 1'b0;
        if (r_full > S_MAX) begin
            r_d     = S_MAX[DATA_W-1:0];
            sat_evt = v1_q;
        end else if (r_full < S_MIN) begin
            r_d     = S_MIN[DATA_W-1:0];
            sat_evt = v1_q;
        end
        v2_d = v1_q;
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        full     = (level_q == LVL_W'(DEPTH));
        pop      = (level_q != '0) && out_ready;
        push     = v2_q && (!full || pop);
        drop     = v2_q && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Clear takes priority over any coinciding increment.
    always_comb begin
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        sat_cnt_d  = sat_cnt_q;
        if (drop && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        if (sat_evt && (sat_cnt_q != '1))
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        if (clr_stats) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            sat_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q        <= '0;
            v1_q       <= 1'b0;
            r_q        <= '0;
            v2_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            sat_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            p_q        <= p_d;
            v1_q       <= v1_d;
            r_q        <= r_d;
            v2_q       <= v2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    // NOTE: storage is not reset; an empty FIFO masks the head, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_q[wr_ptr_q] <= r_q;
    end

    assign out_valid  = (level_q != '0);
    assign out_sample = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_sin_sample_scaler.sv
// Directed bench for sin_sample_scaler: latency, rounding, saturation, FIFO full/drop, reset.
module tb_sin_sample_scaler;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_stats;
    logic [15:0] gain;
    logic        in_valid;
    logic [15:0] in_sample;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [15:0] sat_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sin_sample_scaler dut (
        .clk        (clk),
        .rst        (rst),
        .clr_stats  (clr_stats),
        .gain       (gain),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_stats = 1'b0; gain = 16'h8000;
        in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
        tick(); tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_sample !== 16'd0) $display("FAIL reset_out_sample got %0d want 0", out_sample); else pass_cnt++;
        total_cnt++; if (fifo_level !== 4'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 16'd0 || sat_cnt !== 16'd0)
            $display("FAIL reset_counters got drop=%0d sat=%0d want 0/0", drop_cnt, sat_cnt); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unity_latency();
        gain = 16'h8000; in_sample = 16'd17715; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL unity_early1 got out_valid=%b want 0", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL unity_early2 got out_valid=%b want 0", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL unity_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_sample !== 16'd17715) $display("FAIL unity_value got %0d want 17715", $signed(out_sample)); else pass_cnt++;
        total_cnt++; if (sat_cnt !== 16'd0 || fifo_level !== 4'd1)
            $display("FAIL unity_status got sat=%0d level=%0d want 0/1", sat_cnt, fifo_level); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (fifo_level !== 4'd0 || out_valid !== 1'b0)
            $display("FAIL unity_pop got level=%0d valid=%b want 0/0", fifo_level, out_valid); else pass_cnt++;
    endtask

    task automatic test_rounding();
        logic signed [15:0] exp_s;
        gain = 16'h4000;
        in_sample = 16'd9231;  in_valid = 1'b1; tick();
        in_sample = -16'sd9231; tick();
        in_valid = 1'b0; tick(); tick();
        total_cnt++; if (fifo_level !== 4'd2) $display("FAIL round_level got %0d want 2", fifo_level); else pass_cnt++;
        exp_s = 16'sd4616;
        total_cnt++; if (out_sample !== exp_s) $display("FAIL round_pos got %0d want %0d", $signed(out_sample), exp_s); else pass_cnt++;
        out_ready = 1'b1; tick();
        exp_s = -16'sd4615;
        total_cnt++; if (out_sample !== exp_s) $display("FAIL round_neg got %0d want %0d", $signed(out_sample), exp_s); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (fifo_level !== 4'd0) $display("FAIL round_drain got %0d want 0", fifo_level); else pass_cnt++;
    endtask

    task automatic test_gain_switch();
        in_valid = 1'b1; in_sample = 16'd1000; gain = 16'h8000; tick();
        gain = 16'h4000; tick();
        in_valid = 1'b0; gain = 16'h0000; tick(); tick();
        total_cnt++; if (out_sample !== 16'd1000) $display("FAIL gain_old got %0d want 1000", $signed(out_sample)); else pass_cnt++;
        out_ready = 1'b1; tick();
        total_cnt++; if (out_sample !== 16'd500) $display("FAIL gain_new got %0d want 500", $signed(out_sample)); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (fifo_level !== 4'd0) $display("FAIL gain_drain got %0d want 0", fifo_level); else pass_cnt++;
    endtask

    task automatic test_saturation();
        clear_stats();
        gain = 16'hFFFF;
        in_sample = 16'd32434; in_valid = 1'b1; tick();
        in_sample = -16'sd32434; tick();
        in_valid = 1'b0; tick(); tick();
        total_cnt++; if (sat_cnt !== 16'd2) $display("FAIL sat_count got %0d want 2", sat_cnt); else pass_cnt++;
        total_cnt++; if (out_sample !== 16'h7FFF) $display("FAIL sat_pos got %0d want 32767", $signed(out_sample)); else pass_cnt++;
        out_ready = 1'b1; tick();
        total_cnt++; if (out_sample !== 16'h8000) $display("FAIL sat_neg got %0d want -32768", $signed(out_sample)); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (drop_cnt !== 16'd0 || fifo_level !== 4'd0)
            $display("FAIL sat_tail got drop=%0d level=%0d want 0/0", drop_cnt, fifo_level); else pass_cnt++;
    endtask

    task automatic test_overflow();
        clear_stats();
        gain = 16'h8000; out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_sample = 16'(100 * i + 1);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        total_cnt++; if (fifo_level !== 4'd8) $display("FAIL ovf_level got %0d want 8", fifo_level); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 16'd4) $display("FAIL ovf_drops got %0d want 4", drop_cnt); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total_cnt++; if (out_valid !== 1'b1 || out_sample !== 16'(100 * i + 1))
                $display("FAIL ovf_order[%0d] got valid=%b val=%0d want 1/%0d", i, out_valid, out_sample, 100 * i + 1); else pass_cnt++;
            tick();
        end
        out_ready = 1'b0;
        total_cnt++; if (fifo_level !== 4'd0 || out_valid !== 1'b0)
            $display("FAIL ovf_drain got level=%0d valid=%b want 0/0", fifo_level, out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        clear_stats();
        gain = 16'h8000; out_ready = 1'b0;
        for (int t = 0; t < 15; t++) begin
            in_valid = 1'b1; in_sample = 16'(3000 + t);
            out_ready = (t >= 10);
            if (t >= 10) begin
                total_cnt++; if (fifo_level !== 4'd8 || drop_cnt !== 16'd0 || out_sample !== 16'(3000 + t - 10))
                    $display("FAIL b2b_cycle%0d got level=%0d drop=%0d head=%0d want 8/0/%0d",
                             t, fifo_level, drop_cnt, out_sample, 3000 + t - 10); else pass_cnt++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total_cnt++; if (fifo_level !== 4'd8 || drop_cnt !== 16'd0)
            $display("FAIL b2b_end got level=%0d drop=%0d want 8/0", fifo_level, drop_cnt); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (drop_cnt !== 16'd2 || overflow !== 1'b1)
            $display("FAIL b2b_tail_drops got drop=%0d ovf=%b want 2/1", drop_cnt, overflow); else pass_cnt++;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            total_cnt++; if (out_sample !== 16'(3005 + j))
                $display("FAIL b2b_order[%0d] got %0d want %0d", j, out_sample, 3005 + j); else pass_cnt++;
            tick();
        end
        out_ready = 1'b0;
        total_cnt++; if (fifo_level !== 4'd0) $display("FAIL b2b_drain got %0d want 0", fifo_level); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        gain = 16'hFFFF; out_ready = 1'b0;
        for (int t = 0; t < 7; t++) begin
            in_valid = 1'b1; in_sample = 16'd30000;
            tick();
        end
        in_valid = 1'b0;
        total_cnt++; if (fifo_level !== 4'd5 || sat_cnt !== 16'd6)
            $display("FAIL mid_pre got level=%0d sat=%0d want 5/6", fifo_level, sat_cnt); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || fifo_level !== 4'd0 || out_sample !== 16'd0)
            $display("FAIL mid_async got valid=%b level=%0d out=%0d want 0/0/0", out_valid, fifo_level, out_sample); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 16'd0 || sat_cnt !== 16'd0 || overflow !== 1'b0)
            $display("FAIL mid_stats got drop=%0d sat=%0d ovf=%b want 0/0/0", drop_cnt, sat_cnt, overflow); else pass_cnt++;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total_cnt++; if (out_valid !== 1'b0 || fifo_level !== 4'd0 || sat_cnt !== 16'd0)
                $display("FAIL mid_stale%0d got valid=%b level=%0d sat=%0d want 0/0/0", k, out_valid, fifo_level, sat_cnt); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_unity_latency();
        test_rounding();
        test_gain_switch();
        test_saturation();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
